bcd_seq_adder: RTL and testbench

Multi-digit BCD adder controller built around a single-digit BCD add stage that is reused once per digit, least-significant digit first. It latches two packed BCD operands on a start strobe, validates every digit, sequences the digit additions with carry propagation, and reports the result with a one-cycle done pulse. It sits between the switch/operand logic and the HEX display decoders, and extends the existing one-digit BCD adder to N digits.

---
 rtl/bcd_seq_adder.sv | 269 ++++++++++++++++++++++++++
 tb/tb_bcd_seq_adder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_adder.sv
// -----------------------------------------------------------------------------
// bcd_seq_adder
//
// Multi-digit packed-BCD adder that reuses one single-digit BCD add stage once
// per digit, least-significant digit first. Operands are latched on an
// accepted start, every digit is range-checked, the digits are then added one
// per cycle with a rippling carry, and completion is flagged by a one-cycle
// done pulse. The result outputs hold until the next accepted start.
//
// Optional feature macro: BCD_SEQ_SUB_EN
//   Defined   : adds the 'sub' port. With sub=1 latched at start, B is replaced
//               by its nine's complement after validation and the carry-in is
//               forced to 1, giving the ten's-complement difference A-B
//               (cout=1 means A>=B).
//   Undefined : addition only, no 'sub' port. Cycle timing is identical.
//
// Ports
//   clk      in   1         rising-edge clock
//   rst      in   1         synchronous active-high reset
//   start    in   1         operation request, honoured in IDLE and DONE only
//   a_bcd    in   4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0]
//   b_bcd    in   4*DIGITS  operand B, packed BCD
//   cin      in   1         carry into digit 0
//   sub      in   1         subtract select (BCD_SEQ_SUB_EN builds only)
//   busy     out  1         high from the cycle after accept through last ADD
//   done     out  1         one-cycle completion pulse
//   sum_bcd  out  4*DIGITS  packed BCD result (sum mod 10^DIGITS)
//   cout     out  1         carry out of the top digit
//   err      out  1         an operand digit was greater than 9
//
// Latency from the accepting edge: DIGITS+2 cycles to done on the normal path,
// 2 cycles on the error path. A start in the DONE cycle is accepted, so
// operations can run back to back.
// -----------------------------------------------------------------------------
module bcd_seq_adder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a_bcd,
  input  logic [4*DIGITS-1:0] b_bcd,
  input  logic                cin,
`ifdef BCD_SEQ_SUB_EN
  input  logic                sub,
`endif
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum_bcd,
  output logic                cout,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ADD   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [W-1:0]  a_lat;
  logic [W-1:0]  a_lat_nxt;
  logic [W-1:0]  b_lat;
  logic [W-1:0]  b_lat_nxt;
  logic          cin_lat;
  logic          cin_lat_nxt;
  logic          sub_lat;
  logic          sub_lat_nxt;
  logic          carry;
  logic          carry_nxt;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;

  logic          busy_nxt;
  logic          done_nxt;
  logic [W-1:0]  sum_nxt;
  logic          cout_nxt;
  logic          err_nxt;

  logic          sub_in;
  logic          accept;
  logic [IW+1:0] shamt;
  logic [W-1:0]  a_shift;
  logic [W-1:0]  b_shift;
  logic [3:0]    a_dig;
  logic [3:0]    b_dig;
  logic [4:0]    add_res;
  logic [W-1:0]  digit_mask;
  logic [W-1:0]  digit_ins;

`ifdef BCD_SEQ_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // A BCD digit is legal when it lies in 0..9.
  function automatic logic digit_valid(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

  // Every digit of both operands must be legal.
  function automatic logic operands_valid(input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic ok;
    ok = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (!digit_valid(a[4*d +: 4]) || !digit_valid(b[4*d +: 4])) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // Digit-wise nine's complement; only applied to already-validated operands.
  function automatic logic [W-1:0] nines_complement(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = {W{1'b0}};
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'd9 - v[4*d +: 4];
    end
    return r;
  endfunction

  // Single-digit BCD add: returns {carry_out, digit}.
  function automatic logic [4:0] digit_add(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic       c);
    logic [4:0] s;
    logic [4:0] adj;
    s   = {1'b0, a} + {1'b0, b} + {4'b0000, c};
    adj = s - 5'd10;
    if (s > 5'd9) begin
      return {1'b1, adj[3:0]};
    end else begin
      return {1'b0, s[3:0]};
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Digit datapath: select the current digit pair, add, and build the
  // mask/insert pair used to write the result digit in place.
  // ---------------------------------------------------------------------------
  assign shamt      = {idx, 2'b00};
  assign a_shift    = a_lat >> shamt;
  assign b_shift    = b_lat >> shamt;
  assign a_dig      = a_shift[3:0];
  assign b_dig      = b_shift[3:0];
  assign add_res    = digit_add(a_dig, b_dig, carry);
  assign digit_mask = W'(4'hF) << shamt;
  assign digit_ins  = W'(add_res[3:0]) << shamt;

  // A new operation may be accepted when idle or in the completion cycle.
  assign accept = start && ((state == IDLE) || (state == DONE));

  // Next-state and next-register logic for the sequencer.
  always_comb begin
    state_nxt   = state;
    a_lat_nxt   = a_lat;
    b_lat_nxt   = b_lat;
    cin_lat_nxt = cin_lat;
    sub_lat_nxt = sub_lat;
    carry_nxt   = carry;
    idx_nxt     = idx;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    sum_nxt     = sum_bcd;
    cout_nxt    = cout;
    err_nxt     = err;

    case (state)
      IDLE, DONE: begin
        if (accept) begin
          a_lat_nxt   = a_bcd;
          b_lat_nxt   = b_bcd;
          cin_lat_nxt = cin;
          sub_lat_nxt = sub_in;
          sum_nxt     = {W{1'b0}};
          cout_nxt    = 1'b0;
          err_nxt     = 1'b0;
          busy_nxt    = 1'b1;
          state_nxt   = CHECK;
        end else begin
          state_nxt   = IDLE;
        end
      end

      CHECK: begin
        if (!operands_valid(a_lat, b_lat)) begin
          err_nxt   = 1'b1;
          sum_nxt   = {W{1'b0}};
          cout_nxt  = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end else begin
          // Subtraction is A + (99..9 - B) + 1; validation above saw the
          // original B, so the complement is taken only now.
          b_lat_nxt = sub_lat ? nines_complement(b_lat) : b_lat;
          carry_nxt = sub_lat ? 1'b1 : cin_lat;
          idx_nxt   = {IW{1'b0}};
          state_nxt = ADD;
        end
      end

      ADD: begin
        sum_nxt   = (sum_bcd & ~digit_mask) | digit_ins;
        carry_nxt = add_res[4];
        if (idx == LAST_IDX) begin
          cout_nxt  = add_res[4];
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + IW'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, operand and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_lat   <= {W{1'b0}};
      b_lat   <= {W{1'b0}};
      cin_lat <= 1'b0;
      sub_lat <= 1'b0;
      carry   <= 1'b0;
      idx     <= {IW{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      sum_bcd <= {W{1'b0}};
      cout    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      a_lat   <= a_lat_nxt;
      b_lat   <= b_lat_nxt;
      cin_lat <= cin_lat_nxt;
      sub_lat <= sub_lat_nxt;
      carry   <= carry_nxt;
      idx     <= idx_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      sum_bcd <= sum_nxt;
      cout    <= cout_nxt;
      err     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_seq_adder.sv
`timescale 1ns/1ps
module tb_bcd_seq_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 10000;
`ifdef BCD_SEQ_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_bcd;
  logic [W-1:0] b_bcd;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_bcd;
  logic         cout;
  logic         err;

  int tests = 0;
  int fails = 0;

  bcd_seq_adder #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_bcd   (a_bcd),
    .b_bcd   (b_bcd),
    .cin     (cin),
`ifdef BCD_SEQ_SUB_EN
    .sub     (sub),
`endif
    .busy    (busy),
    .done    (done),
    .sum_bcd (sum_bcd),
    .cout    (cout),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  function automatic int bcd_to_int(input logic [W-1:0] v);
    int r;
    r = 0;
    for (int d = DIGITS - 1; d >= 0; d--) r = r * 10 + int'(v[4*d +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad_digit(input logic [W-1:0] v);
    for (int d = 0; d < DIGITS; d++) if (v[4*d +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic s, output logic [W-1:0] r, output logic co,
                       output logic er);
    int t;
    er = has_bad_digit(a) || has_bad_digit(b);
    if (er) begin
      r  = '0;
      co = 1'b0;
    end else begin
      if (s) t = bcd_to_int(a) - bcd_to_int(b) + MAXV;
      else   t = bcd_to_int(a) + bcd_to_int(b) + int'(c);
      co = (t >= MAXV);
      r  = int_to_bcd(t % MAXV);
    end
  endtask

  // Transaction-level model: which edge accepted a start, when done is due.
  int           cyc = 0;
  bit           started = 1'b0;
  bit           have_op = 1'b0;
  int           done_edge = 0;
  logic [W-1:0] exp_sum;
  logic         exp_cout;
  logic         exp_err;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      started = 1'b1;
      have_op = 1'b0;
    end else if (started && start && (!have_op || cyc > done_edge)) begin
      model(a_bcd, b_bcd, cin, HAS_SUB && sub, exp_sum, exp_cout, exp_err);
      have_op   = 1'b1;
      done_edge = cyc + (exp_err ? 1 : DIGITS + 1);
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("busy", busy, have_op && (cyc < done_edge));
      chk("done", done, have_op && (cyc == done_edge));
      if (!have_op) begin
        chk("rst_sum", sum_bcd, 0);
        chk("rst_cout", cout, 0);
        chk("rst_err", err, 0);
      end else if (cyc >= done_edge) begin
        chk("sum", sum_bcd, exp_sum);
        chk("cout", cout, exp_cout);
        chk("err", err, exp_err);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_done(inout int n, inout int nb);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      nb += int'(busy);
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected a pulse", n);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s, input bit in_place, output int lat, output int nb);
    if (!in_place) @(negedge clk);
    a_bcd = a; b_bcd = b; cin = c; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_bcd = W'($urandom); b_bcd = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lat = 1;
    nb  = int'(busy);
    wait_done(lat, nb);
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int d = 0; d < DIGITS; d++) begin
      if ($urandom_range(0, 59) == 0) r[4*d +: 4] = 4'($urandom_range(10, 15));
      else                            r[4*d +: 4] = 4'($urandom_range(0, 9));
    end
    return r;
  endfunction

  initial begin : main
    int lat;
    int nb;
    int ndone;
    logic [W-1:0] mr;
    logic mc;
    logic me;

    rst = 1'b1; start = 1'b0; a_bcd = '0; b_bcd = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum_bcd, 0);
    rst = 1'b0;

    // Pin the model with hand-computed values.
    model(16'h1234, 16'h5678, 1'b0, 1'b0, mr, mc, me);
    chk("model_1234_5678", {mr, 7'd0, mc, 7'd0, me}, {16'h6912, 16'h0000});
    model(16'h9999, 16'h0000, 1'b1, 1'b0, mr, mc, me);
    chk("model_wrap", {mr, 7'd0, mc, 7'd0, me}, {16'h0000, 16'h0100});
    model(16'h12A4, 16'h0001, 1'b0, 1'b0, mr, mc, me);
    chk("model_err", {mr, 7'd0, mc, 7'd0, me}, {16'h0000, 16'h0001});

    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, lat, nb);
    chk("t1_latency", lat, 6);
    chk("t1_busy_cycles", nb, 5);
    chk("t1_sum", sum_bcd, 16'h6912);
    chk("t1_cout", cout, 0);
    chk("t1_err", err, 0);

    run_op(16'h9999, 16'h0000, 1'b1, 1'b0, 1'b0, lat, nb);
    chk("wrap_sum", sum_bcd, 16'h0000);
    chk("wrap_cout", cout, 1);

    run_op(16'h0009, 16'h0009, 1'b1, 1'b0, 1'b0, lat, nb);
    chk("nine_sum", sum_bcd, 16'h0019);
    chk("nine_cout", cout, 0);

    run_op(16'h12A4, 16'h0001, 1'b0, 1'b0, 1'b0, lat, nb);
    chk("err_latency", lat, 2);
    chk("err_flag", err, 1);
    chk("err_sum", sum_bcd, 0);
    chk("err_cout", cout, 0);

    run_op(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, lat, nb);
    chk("err_cleared", err, 0);
    chk("after_err_sum", sum_bcd, 16'h0003);

    // Start pulsed mid-ADD is ignored.
    @(negedge clk);
    a_bcd = 16'h1111; b_bcd = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    a_bcd = 16'h9999; b_bcd = 16'h9999; cin = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 4; nb = 0;
    wait_done(lat, nb);
    chk("ignored_start_latency", lat, 6);
    chk("ignored_start_sum", sum_bcd, 16'h3333);
    repeat (8) @(negedge clk);
    chk("ignored_start_hold", sum_bcd, 16'h3333);

    // Back-to-back: start held in the done cycle.
    run_op(16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0, lat, nb);
    chk("b2b_first_sum", sum_bcd, 16'h0300);
    run_op(16'h4444, 16'h5555, 1'b1, 1'b0, 1'b1, lat, nb);
    chk("b2b_latency", lat, 6);
    chk("b2b_sum", sum_bcd, 16'h0000);
    chk("b2b_cout", cout, 1);

    // Reset while ADD works on digit 2.
    @(negedge clk);
    a_bcd = 16'h5678; b_bcd = 16'h1234; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum_bcd, 0);
    chk("abort_cout", cout, 0);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      ndone += int'(done);
    end
    chk("abort_no_done", ndone, 0);

`ifdef BCD_SEQ_SUB_EN
    run_op(16'h0050, 16'h0025, 1'b1, 1'b1, 1'b0, lat, nb);
    chk("sub_pos_sum", sum_bcd, 16'h0025);
    chk("sub_pos_cout", cout, 1);
    run_op(16'h0025, 16'h0050, 1'b0, 1'b1, 1'b0, lat, nb);
    chk("sub_neg_sum", sum_bcd, 16'h9975);
    chk("sub_neg_cout", cout, 0);
    run_op(16'h4321, 16'h4321, 1'b0, 1'b1, 1'b0, lat, nb);
    chk("sub_eq_latency", lat, 6);
    chk("sub_eq_sum", sum_bcd, 16'h0000);
    chk("sub_eq_cout", cout, 1);
`endif

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 3) == 0);
      a_bcd = rand_bcd();
      b_bcd = rand_bcd();
      cin   = 1'($urandom);
      sub   = 1'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
